enemy_formation_ctrl: RTL and testbench
=======================================

Name: enemy_formation_ctrl

Overview:
- Formation-level controller that drives the shared movement and kill inputs of every per-enemy sprite block.
- Issues the march commands: direction X, step-down, move strobe.
- Mirrors the formation bounding box and tracks which enemies are alive from per-enemy hit reports.
- Asserts delete_enemies when the wave is cleared or the formation lands. Runs once per frame on frame_clk.

Parameters:
- NUM_ENEMIES, 8, number of enemy instances (width of hit_vec/alive_mask)
- INIT_X, 100, formation left edge after reset/restart (pixels)
- INIT_Y, 40, formation top edge after reset/restart
- FORM_W, 400, formation bounding-box width
- FORM_H, 100, formation bounding-box height
- LEFT_LIMIT, 10, minimum legal left edge
- RIGHT_LIMIT, 629, maximum legal right edge (x+FORM_W-1)
- LAND_Y, 440, bottom edge (y+FORM_H-1) at or beyond which the formation has landed
- DROP_PIXELS, 10, down-steps per edge bounce
- MOVE_DIV, 4, frames per move step (>=1)

Ports:
- frame_clk  in  1  frame clock, one edge per video frame
- Reset  in  1  synchronous, active-high
- start  in  1  level; begins/restarts a wave
- hit_vec  in  NUM_ENEMIES  per-enemy hit, level, sampled each frame_clk edge
- enemy_direction_X  out  1  0=left, 1=right
- enemy_direction_Y  out  1  1=move down this step (X held)
- enemy_move  out  1  1=consumers apply one step at next edge
- formation_x  out  10  current left edge
- formation_y  out  10  current top edge
- alive_mask  out  NUM_ENEMIES  1=enemy alive
- delete_enemies  out  1  kill all sprites
- wave_cleared  out  1  sticky until restart
- invaders_landed  out  1  sticky until restart

Behaviour:
- Reset is synchronous, active-high; clock is frame_clk.
- All outputs are registered. Reset values:
  - state=IDLE, formation_x=INIT_X, formation_y=INIT_Y
  - alive_mask=all ones, enemy_direction_X=1, enemy_direction_Y=0, enemy_move=0
  - delete_enemies=0, wave_cleared=0, invaders_landed=0, div_cnt=0, drop_cnt=0
- Consumer contract, at each edge where enemy_move=1:
  - Y=0: x±=1 per direction_X.
  - Y=1: y+=1, x unchanged.
- Controller mirrors the consumer: at every edge where the current enemy_move=1, formation_x/y update by the same rule using the current direction outputs.
- States: IDLE, MARCH, DESCEND, CLEARED, LANDED.
- IDLE:
  - enemy_move=0.
  - start=1 → MARCH; div_cnt=0.
- MARCH / DESCEND, each edge:
  - div_cnt++.
  - When div_cnt==MOVE_DIV-1: div_cnt←0 and enemy_move←1; otherwise enemy_move←0. One-cycle strobe.
- Edge check in MARCH, evaluated on post-update position at an edge where a move was applied:
  - Right edge: direction_X=1 and formation_x+FORM_W-1==RIGHT_LIMIT → DESCEND; direction_Y←1; drop_cnt←0.
  - Left edge: direction_X=0 and formation_x==LEFT_LIMIT → same transition.
- DESCEND:
  - Each applied move increments drop_cnt.
  - At drop_cnt==DROP_PIXELS: direction_Y←0, direction_X toggles, → MARCH.
- Hits:
  - In MARCH/DESCEND, alive_mask ← alive_mask & ~hit_vec.
  - Hits are ignored in IDLE/CLEARED/LANDED.
  - Multiple simultaneous hits are all applied.
- Clear: next alive_mask==0 → CLEARED; wave_cleared←1, delete_enemies←1, enemy_move←0.
- Land: post-update formation_y+FORM_H-1 >= LAND_Y → LANDED; invaders_landed←1, delete_enemies←1, enemy_move←0.
- Priority on the same edge: Reset > clear > land > edge bounce.
- CLEARED/LANDED hold all outputs. On start=1, reload everything to reset values except state → MARCH. delete_enemies deasserts on that edge.
- Arithmetic is 10-bit unsigned. Bounds checks use 11-bit sums so no wrap occurs.
- Reset mid-operation: returns to IDLE at that edge, regardless of state.

Optional Feature:
- Macro ENEMY_SPEEDUP_EN.
- Defined: effective divider depends on the alive count (popcount):
  - count <= NUM_ENEMIES/2 → max(1, MOVE_DIV/2)
  - count <= NUM_ENEMIES/4 → max(1, MOVE_DIV/4)
  - count==1 → 1
  - Divider change takes effect at the next div_cnt wrap; if div_cnt ≥ new divider, wrap immediately.
- Undefined: divider is fixed at MOVE_DIV.

Test Plan:
- Reset then start=1, defaults: enemy_move pulses every 4th frame. First right-bounce at formation_x=230 after 130 moves (520 frames); enemy_direction_Y=1 for 10 moves, formation_y 40→50; then direction_X=0.
- Continue march: left bounce at formation_x=10 after 220 more moves; direction_X returns to 1 after 10 drops, formation_y=60.
- LAND_Y=150: after first descent y=50; second descent first drop gives y=51 → invaders_landed=1, delete_enemies=1, enemy_move=0, outputs frozen.
- Hits: hit_vec=0x81 one frame → alive_mask=0x7E. Then hit_vec=0x7E → alive_mask=0, wave_cleared=1, delete_enemies=1. Same-edge landing still reports CLEARED only.
- Restart: start=1 in CLEARED → formation_x=100, formation_y=40, alive_mask=0xFF, delete_enemies=0, state MARCH. Reset asserted during DESCEND → IDLE with reset values next edge.
- ENEMY_SPEEDUP_EN: kill 4 of 8 → move period 2 frames; kill 6 → 1 frame; without macro, period stays 4.

Source files
------------

// File: rtl/enemy_formation_ctrl.sv
// Formation march/bounce/descend controller with hit tracking and wave end.
// Define ENEMY_SPEEDUP_EN to shorten the move divider as enemies die.
module enemy_formation_ctrl #(
  parameter int NUM_ENEMIES = 8,
  parameter int INIT_X      = 100,
  parameter int INIT_Y      = 40,
  parameter int FORM_W      = 400,
  parameter int FORM_H      = 100,
  parameter int LEFT_LIMIT  = 10,
  parameter int RIGHT_LIMIT = 629,
  parameter int LAND_Y      = 440,
  parameter int DROP_PIXELS = 10,
  parameter int MOVE_DIV    = 4
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic                   start,
  input  logic [NUM_ENEMIES-1:0] hit_vec,
  output logic                   enemy_direction_X,
  output logic                   enemy_direction_Y,
  output logic                   enemy_move,
  output logic [9:0]             formation_x,
  output logic [9:0]             formation_y,
  output logic [NUM_ENEMIES-1:0] alive_mask,
  output logic                   delete_enemies,
  output logic                   wave_cleared,
  output logic                   invaders_landed
);

  typedef enum logic [2:0] {
    IDLE, MARCH, DESCEND, CLEARED, LANDED
  } state_t;

  localparam int DW = $clog2(MOVE_DIV + 1);
  localparam int PW = $clog2(DROP_PIXELS + 1);

  state_t                 state;
  logic [DW-1:0]          div_cnt;
  logic [DW-1:0]          div_last;
  logic [PW-1:0]          drop_cnt;
  logic [PW-1:0]          drop_nxt;
  logic [9:0]             nx;
  logic [9:0]             ny;
  logic [10:0]            right_edge;
  logic [10:0]            bottom_edge;
  logic [NUM_ENEMIES-1:0] mask_nxt;
  logic                   bounce;
  logic                   land_now;
  logic                   finished;
  logic                   reload;

  // Position after the step the sprites apply on this edge.
  always_comb begin
    nx = formation_x;
    ny = formation_y;
    if (enemy_move) begin
      if (enemy_direction_Y)
        ny = formation_y + 10'd1;
      else if (enemy_direction_X)
        nx = formation_x + 10'd1;
      else
        nx = formation_x - 10'd1;
    end
  end

  assign right_edge  = {1'b0, nx} + 11'(FORM_W - 1);
  assign bottom_edge = {1'b0, ny} + 11'(FORM_H - 1);
  assign land_now    = bottom_edge >= 11'(LAND_Y);
  assign bounce      = enemy_move && !enemy_direction_Y &&
                       (enemy_direction_X ?
                        right_edge == 11'(RIGHT_LIMIT) :
                        nx == 10'(LEFT_LIMIT));
  assign mask_nxt    = alive_mask & ~hit_vec;
  assign drop_nxt    = drop_cnt + PW'(1);
  assign finished    = (state == CLEARED) || (state == LANDED);
  assign reload      = Reset || (finished && start);

`ifdef ENEMY_SPEEDUP_EN
  localparam int CW   = $clog2(NUM_ENEMIES + 1);
  localparam int DIV2 = (MOVE_DIV / 2 > 1) ? MOVE_DIV / 2 : 1;
  localparam int DIV4 = (MOVE_DIV / 4 > 1) ? MOVE_DIV / 4 : 1;

  logic [CW-1:0] alive_cnt;

  always_comb begin
    alive_cnt = '0;
    for (int i = 0; i < NUM_ENEMIES; i++)
      alive_cnt = alive_cnt + CW'(alive_mask[i]);
  end

  always_comb begin
    div_last = DW'(MOVE_DIV - 1);
    unique case (1'b1)
      alive_cnt == CW'(1):
        div_last = '0;
      alive_cnt > CW'(1) &&
      alive_cnt <= CW'(NUM_ENEMIES / 4):
        div_last = DW'(DIV4 - 1);
      alive_cnt > CW'(1) &&
      alive_cnt > CW'(NUM_ENEMIES / 4) &&
      alive_cnt <= CW'(NUM_ENEMIES / 2):
        div_last = DW'(DIV2 - 1);
      default: ;
    endcase
  end
`else
  assign div_last = DW'(MOVE_DIV - 1);
`endif

  always_ff @(posedge frame_clk) begin
    if (reload) begin
      state             <= Reset ? IDLE : MARCH;
      formation_x       <= 10'(INIT_X);
      formation_y       <= 10'(INIT_Y);
      alive_mask        <= '1;
      enemy_direction_X <= 1'b1;
      enemy_direction_Y <= 1'b0;
      enemy_move        <= 1'b0;
      delete_enemies    <= 1'b0;
      wave_cleared      <= 1'b0;
      invaders_landed   <= 1'b0;
      div_cnt           <= '0;
      drop_cnt          <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          enemy_move <= 1'b0;
          if (start) begin
            state   <= MARCH;
            div_cnt <= '0;
          end
        end
        MARCH, DESCEND: begin
          formation_x <= nx;
          formation_y <= ny;
          alive_mask  <= mask_nxt;
          // >= lets a shorter divider take effect without waiting a lap
          if (div_cnt >= div_last) begin
            div_cnt    <= '0;
            enemy_move <= 1'b1;
          end else begin
            div_cnt    <= div_cnt + DW'(1);
            enemy_move <= 1'b0;
          end
          if (mask_nxt == '0) begin
            state          <= CLEARED;
            wave_cleared   <= 1'b1;
            delete_enemies <= 1'b1;
            enemy_move     <= 1'b0;
          end else if (land_now) begin
            state           <= LANDED;
            invaders_landed <= 1'b1;
            delete_enemies  <= 1'b1;
            enemy_move      <= 1'b0;
          end else if (state == MARCH && bounce) begin
            state             <= DESCEND;
            enemy_direction_Y <= 1'b1;
            drop_cnt          <= '0;
          end else if (state == DESCEND && enemy_move) begin
            drop_cnt <= drop_nxt;
            if (drop_nxt == PW'(DROP_PIXELS)) begin
              state             <= MARCH;
              enemy_direction_Y <= 1'b0;
              enemy_direction_X <= ~enemy_direction_X;
            end
          end
        end
        CLEARED, LANDED: ;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_enemy_formation_ctrl.sv
// Bench for enemy_formation_ctrl: vector table, march/land/speedup
// sequences and random traffic against a frame-level reference model.
module tb_enemy_formation_ctrl;

  localparam int MD     = 4;
  localparam int LAND_A = 440;
  localparam int LAND_B = 150;
`ifdef ENEMY_SPEEDUP_EN
  localparam bit SPEEDUP = 1'b1;
`else
  localparam bit SPEEDUP = 1'b0;
`endif

  typedef struct {
    int x, y, cnt, drops, mode;
    bit dx, dy, mv, del, clr, lnd;
    bit [7:0] mask;
  } m_t;

  typedef struct {
    bit       r;
    bit       s;
    bit [7:0] h;
    int       n;
    bit [9:0] ex;
    bit [9:0] ey;
    bit [7:0] em;
    bit [2:0] ef;
  } vec_t;

  logic       frame_clk = 1'b0;
  logic       Reset     = 1'b1;
  logic       start     = 1'b0;
  logic [7:0] hit_vec   = 8'h00;

  logic       a_dx, a_dy, a_mv, a_del, a_clr, a_lnd;
  logic [9:0] a_x, a_y;
  logic [7:0] a_mask;
  logic       b_dx, b_dy, b_mv, b_del, b_clr, b_lnd;
  logic [9:0] b_x, b_y;
  logic [7:0] b_mask;
  logic [33:0] a_pk, b_pk;

  int   n_chk  = 0;
  int   n_fail = 0;
  bit   mvalid = 1'b0;
  m_t   ma, mb;
  vec_t tbl[10];

  always #5 frame_clk = ~frame_clk;

  enemy_formation_ctrl dut (
    .frame_clk(frame_clk), .Reset(Reset), .start(start),
    .hit_vec(hit_vec),
    .enemy_direction_X(a_dx), .enemy_direction_Y(a_dy),
    .enemy_move(a_mv), .formation_x(a_x), .formation_y(a_y),
    .alive_mask(a_mask), .delete_enemies(a_del),
    .wave_cleared(a_clr), .invaders_landed(a_lnd)
  );

  enemy_formation_ctrl #(.LAND_Y(LAND_B)) dut_land (
    .frame_clk(frame_clk), .Reset(Reset), .start(start),
    .hit_vec(hit_vec),
    .enemy_direction_X(b_dx), .enemy_direction_Y(b_dy),
    .enemy_move(b_mv), .formation_x(b_x), .formation_y(b_y),
    .alive_mask(b_mask), .delete_enemies(b_del),
    .wave_cleared(b_clr), .invaders_landed(b_lnd)
  );

  assign a_pk = {a_dx, a_dy, a_mv, a_x, a_y, a_mask,
                 a_del, a_clr, a_lnd};
  assign b_pk = {b_dx, b_dy, b_mv, b_x, b_y, b_mask,
                 b_del, b_clr, b_lnd};

  function automatic m_t m_init();
    m_t m;
    m.x = 100; m.y = 40; m.cnt = 0; m.drops = 0;
    m.mode = 0; m.dx = 1'b1; m.dy = 1'b0; m.mv = 1'b0;
    m.del = 1'b0; m.clr = 1'b0; m.lnd = 1'b0;
    m.mask = 8'hFF;
    return m;
  endfunction

  // Frames per move for a given set of survivors.
  function automatic int m_period(input bit [7:0] mask);
    int c;
    c = $countones(mask);
    if (SPEEDUP && c == 1) return 1;
    if (SPEEDUP && c <= 2) return (MD / 4 > 1) ? MD / 4 : 1;
    if (SPEEDUP && c <= 4) return (MD / 2 > 1) ? MD / 2 : 1;
    return MD;
  endfunction

  // mode: 0 idle, 1 wave running, 2 wave over.
  function automatic m_t m_step(input m_t m, input bit r,
                                input bit s, input bit [7:0] h,
                                input int land_y);
    m_t n;
    if (r) return m_init();
    n = m;
    if (m.mode != 1) begin
      if (s) begin
        n = m_init();
        n.mode = 1;
      end
      return n;
    end
    if (m.mv) begin
      if (m.dy) n.y = m.y + 1;
      else n.x = m.dx ? m.x + 1 : m.x - 1;
    end
    if (m.cnt >= m_period(m.mask) - 1) begin
      n.cnt = 0; n.mv = 1'b1;
    end else begin
      n.cnt = m.cnt + 1; n.mv = 1'b0;
    end
    n.mask = m.mask & ~h;
    if (n.mask == 8'h00) begin
      n.mode = 2; n.clr = 1'b1; n.del = 1'b1; n.mv = 1'b0;
    end else if (n.y + 99 >= land_y) begin
      n.mode = 2; n.lnd = 1'b1; n.del = 1'b1; n.mv = 1'b0;
    end else if (m.mv && !m.dy) begin
      if ((m.dx && n.x + 399 == 629) || (!m.dx && n.x == 10)) begin
        n.dy = 1'b1; n.drops = 0;
      end
    end else if (m.mv && m.dy) begin
      n.drops = m.drops + 1;
      if (n.drops == 10) begin
        n.dy = 1'b0; n.dx = !m.dx;
      end
    end
    return n;
  endfunction

  function automatic logic [33:0] m_pack(input m_t m);
    return {m.dx, m.dy, m.mv, 10'(m.x), 10'(m.y), m.mask,
            m.del, m.clr, m.lnd};
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic tick(input bit r, input bit s, input bit [7:0] h);
    Reset = r; start = s; hit_vec = h;
    if (r) mvalid = 1'b1;
    if (mvalid) begin
      ma = m_step(ma, r, s, h, LAND_A);
      mb = m_step(mb, r, s, h, LAND_B);
    end
    @(posedge frame_clk);
    @(negedge frame_clk);
    if (mvalid) begin
      chk("model_a", 64'(a_pk), 64'(m_pack(ma)));
      chk("model_b", 64'(b_pk), 64'(m_pack(mb)));
    end
  endtask

  task automatic march_run();
    int phase, cnt;
    bit pdy, pbl;
    logic [9:0] bx;
    phase = 0; cnt = 0; pbl = 1'b0; bx = '0;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h00);
    pdy = a_dy;
    for (int c = 0; c < 4000 && phase < 5; c++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (!pdy && a_dy) begin
        if (phase == 0)
          chk("bounce_r", {a_x, a_y, 10'(cnt)},
              {10'd230, 10'd40, 10'd130});
        else if (phase == 2)
          chk("bounce_l", {a_x, a_y, 10'(cnt)},
              {10'd10, 10'd50, 10'd220});
        else
          chk("bounce_r2", {a_x, a_y, 10'(cnt)},
              {10'd230, 10'd60, 10'd220});
        phase++; cnt = 0;
      end else if (pdy && !a_dy) begin
        if (phase == 1)
          chk("descend1", {a_y, a_dx, 10'(cnt)},
              {10'd50, 1'b0, 10'd10});
        else
          chk("descend2", {a_y, a_dx, 10'(cnt)},
              {10'd60, 1'b1, 10'd10});
        phase++; cnt = 0;
      end
      if (a_mv) cnt++;
      if (b_lnd && !pbl) begin
        chk("land_b", {b_y, b_del, b_mv, b_clr},
            {10'd51, 3'b100});
        bx = b_x;
      end
      pbl = b_lnd; pdy = a_dy;
    end
    chk("march_done", 64'(phase), 64'd5);
    chk("land_frozen", {b_lnd, b_x, b_y}, {1'b1, bx, 10'd51});
    repeat (3) tick(1'b0, 1'b0, 8'h00);
    chk("in_descend", 64'(a_dy), 64'd1);
    tick(1'b1, 1'b0, 8'h00);
    chk("reset_descend",
        {a_x, a_y, a_dx, a_dy, a_mv, a_mask, a_del, a_clr, a_lnd},
        {10'd100, 10'd40, 3'b100, 8'hFF, 3'b000});
    repeat (6) tick(1'b0, 1'b0, 8'h00);
    chk("idle_hold", {a_mv, a_x}, {1'b0, 10'd100});
  endtask

  task automatic same_edge();
    bit found;
    found = 1'b0;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h00);
    for (int c = 0; c < 3000 && !found; c++) begin
      if (b_mv && b_dy && b_y == 10'd50) begin
        tick(1'b0, 1'b0, 8'hFF);
        found = 1'b1;
        chk("clear_over_land", {b_clr, b_lnd, b_del, b_mv, b_y},
            {4'b1010, 10'd51});
      end else begin
        tick(1'b0, 1'b0, 8'h00);
      end
    end
    chk("same_edge_seen", 64'(found), 64'd1);
  endtask

  task automatic measure(output int gap);
    int last, prev;
    last = -1; prev = -1;
    for (int c = 0; c < 16; c++) begin
      tick(1'b0, 1'b0, 8'h00);
      if (a_mv) begin
        prev = last; last = c;
      end
    end
    gap = (prev < 0) ? -1 : last - prev;
  endtask

  task automatic speedup();
    int gap;
    tick(1'b1, 1'b0, 8'h00);
    tick(1'b0, 1'b1, 8'h00);
    repeat (5) tick(1'b0, 1'b0, 8'h00);
    measure(gap);
    chk("period_full", 64'(gap), 64'(MD));
    tick(1'b0, 1'b0, 8'h0F);
    measure(gap);
    chk("period_half", 64'(gap), 64'(SPEEDUP ? 2 : MD));
    tick(1'b0, 1'b0, 8'h30);
    measure(gap);
    chk("period_quarter", 64'(gap), 64'(SPEEDUP ? 1 : MD));
  endtask

  task automatic rand_run();
    tick(1'b1, 1'b0, 8'h00);
    for (int c = 0; c < 6000; c++) begin
      bit r, s;
      bit [7:0] h;
      int pr;
      pr = (c < 3000) ? 100 : 700;
      r = ($urandom_range(0, 499) == 0);
      s = ($urandom_range(0, 24) == 0);
      h = '0;
      for (int k = 0; k < 8; k++)
        h[k] = ($urandom_range(0, pr - 1) == 0);
      tick(r, s, h);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1, 10'd100, 10'd40, 8'hFF, 3'b000};
    tbl[1] = '{1'b0, 1'b1, 8'h00, 1, 10'd100, 10'd40, 8'hFF, 3'b000};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 3, 10'd100, 10'd40, 8'hFF, 3'b000};
    tbl[3] = '{1'b0, 1'b0, 8'h81, 1, 10'd100, 10'd40, 8'h7E, 3'b000};
    tbl[4] = '{1'b0, 1'b0, 8'h00, 1, 10'd101, 10'd40, 8'h7E, 3'b000};
    tbl[5] = '{1'b0, 1'b0, 8'h7E, 1, 10'd101, 10'd40, 8'h00, 3'b110};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 5, 10'd101, 10'd40, 8'h00, 3'b110};
    tbl[7] = '{1'b0, 1'b1, 8'h00, 1, 10'd100, 10'd40, 8'hFF, 3'b000};
    tbl[8] = '{1'b0, 1'b0, 8'hFF, 1, 10'd100, 10'd40, 8'h00, 3'b110};
    tbl[9] = '{1'b1, 1'b0, 8'h00, 1, 10'd100, 10'd40, 8'hFF, 3'b000};
    @(negedge frame_clk);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < tbl[i].n; k++)
        tick(tbl[i].r, tbl[i].s, tbl[i].h);
      chk($sformatf("vec%0d", i),
          {a_x, a_y, a_mask, a_del, a_clr, a_lnd},
          {tbl[i].ex, tbl[i].ey, tbl[i].em, tbl[i].ef});
    end
    march_run();
    same_edge();
    speedup();
    rand_run();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
